// File: rtl/pudding_pkg.sv
// Shared types and constants for the PUDDING DAC serial loader.
// Op codes, loader FSM states and the default chain length.
package pudding_pkg;

    localparam int PUDDING_NBITS = 128;

    typedef enum logic [1:0] {
        OP_WRITE        = 2'd0,
        OP_READ         = 2'd1,
        OP_WRITE_VERIFY = 2'd2,
        OP_SET_EN       = 2'd3
    } pudding_op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT_W = 3'd1,
        ST_XFER_W  = 3'd2,
        ST_XFER_R  = 3'd3,
        ST_SHIFT_R = 3'd4,
        ST_RESP    = 3'd5
    } pudding_state_e;

endpackage

// File: rtl/pudding_bit_timer.sv
// Bit-period timer for the PUDDING serial loader.
// Divides clk into DIV-cycle bit periods and counts bits up to NBITS.
module pudding_bit_timer
    import pudding_pkg::*;
#(
    parameter int NBITS = PUDDING_NBITS,
    parameter int DIV   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic run,
    output logic bit_strobe,
    output logic strobe_next,
    output logic last_bit
);

    localparam int BW = $clog2(NBITS + 1);

    logic [BW-1:0] bit_cnt;

    assign last_bit = (bit_cnt == BW'(NBITS - 1));

    // Count completed bit periods, saturating at NBITS
    always_ff @(posedge clk) begin
        if (!rst_n || start) begin
            bit_cnt <= '0;
        end else if (run && bit_strobe && (bit_cnt != BW'(NBITS))) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    generate
        if (DIV == 1) begin : g_nodiv
            assign bit_strobe  = 1'b1;
            assign strobe_next = 1'b1;
        end else begin : g_div
            localparam int DW = $clog2(DIV);

            logic [DW-1:0] div_cnt;

            assign bit_strobe  = (div_cnt == DW'(DIV - 1));
            assign strobe_next = (div_cnt == DW'(DIV - 2));

            // Track the cycle position inside the current bit period
            always_ff @(posedge clk) begin
                if (!rst_n || start) begin
                    div_cnt <= '0;
                end else if (run) begin
                    div_cnt <= bit_strobe ? '0 : div_cnt + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/pudding_loader.sv
// Host-side serial load master for the PUDDING DAC core.
// Shifts words in, transfers to state, and reads state back over the chain.
module pudding_loader
    import pudding_pkg::*;
#(
    parameter int NBITS = PUDDING_NBITS,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [NBITS-1:0] cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [NBITS-1:0] rsp_data,
    output logic             rsp_mismatch,
    output logic             datum_o,
    output logic             shift_o,
    output logic             transfer_o,
    output logic             dir_o,
    output logic             en_o,
    input  logic             sdo_i
);

    localparam logic DIV1 = (DIV == 1);

    pudding_state_e   state;
    pudding_state_e   state_next;
    pudding_op_e      op_in;
    pudding_op_e      op_q;
    logic [NBITS-1:0] word;
    logic [NBITS-1:0] tx;
    logic [NBITS-1:0] rd_next;
    logic             accept;
    logic             datum_n;
    logic             shift_n;
    logic             xfer_n;
    logic             dir_n;
    logic             t_start;
    logic             t_run;
    logic             bit_strobe;
    logic             strobe_next;
    logic             last_bit;

    assign op_in     = pudding_op_e'(cmd_op);
    assign cmd_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign accept    = cmd_valid && cmd_ready;
    assign rd_next   = {rsp_data[NBITS-2:0], sdo_i};

    assign t_run   = (state == ST_SHIFT_W) || (state == ST_SHIFT_R);
    assign t_start = ((state_next == ST_SHIFT_W) && (state != ST_SHIFT_W))
                  || ((state_next == ST_SHIFT_R) && (state != ST_SHIFT_R));

    pudding_bit_timer #(
        .NBITS(NBITS),
        .DIV  (DIV)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (t_start),
        .run        (t_run),
        .bit_strobe (bit_strobe),
        .strobe_next(strobe_next),
        .last_bit   (last_bit)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the pin values to register for the coming cycle
    always_comb begin
        state_next = state;
        datum_n    = 1'b0;
        shift_n    = 1'b0;
        xfer_n     = 1'b0;
        dir_n      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    unique case (op_in)
                        OP_WRITE, OP_WRITE_VERIFY: begin
                            state_next = ST_SHIFT_W;
                            datum_n    = cmd_data[NBITS-1];
                            shift_n    = DIV1;
                        end
                        OP_READ: begin
                            state_next = ST_XFER_R;
                            xfer_n     = 1'b1;
                        end
                        default: begin
                            state_next = ST_RESP;
                        end
                    endcase
                end
            end
            ST_SHIFT_W: begin
                if (bit_strobe && last_bit) begin
                    state_next = ST_XFER_W;
                    xfer_n     = 1'b1;
                    dir_n      = 1'b1;
                end else begin
                    datum_n = bit_strobe ? tx[NBITS-1] : datum_o;
                    shift_n = strobe_next;
                end
            end
            ST_XFER_W: begin
                if (op_q == OP_WRITE_VERIFY) begin
                    state_next = ST_XFER_R;
                    xfer_n     = 1'b1;
                end else begin
                    state_next = ST_RESP;
                end
            end
            ST_XFER_R: begin
                state_next = ST_SHIFT_R;
                shift_n    = DIV1;
            end
            ST_SHIFT_R: begin
                if (bit_strobe && last_bit) begin
                    state_next = ST_RESP;
                end else begin
                    shift_n = strobe_next;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Registered pins, latched command and readback datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            datum_o      <= 1'b0;
            shift_o      <= 1'b0;
            transfer_o   <= 1'b0;
            dir_o        <= 1'b0;
            en_o         <= 1'b0;
            op_q         <= OP_WRITE;
            word         <= '0;
            tx           <= '0;
            rsp_data     <= '0;
            rsp_mismatch <= 1'b0;
        end else begin
            datum_o    <= datum_n;
            shift_o    <= shift_n;
            transfer_o <= xfer_n;
            dir_o      <= dir_n;
            if (accept) begin
                op_q         <= op_in;
                word         <= cmd_data;
                tx           <= cmd_data << 1;
                rsp_data     <= '0;
                rsp_mismatch <= 1'b0;
                if (op_in == OP_SET_EN) begin
                    en_o <= cmd_data[0];
                end
            end
            if ((state == ST_SHIFT_W) && bit_strobe) begin
                tx <= tx << 1;
            end
            if ((state == ST_SHIFT_R) && bit_strobe) begin
                rsp_data <= rd_next;
                if (last_bit) begin
                    rsp_mismatch <= (op_q == OP_WRITE_VERIFY)
                                 && (rd_next != word);
                end
            end
        end
    end

endmodule

// File: doc/pudding_loader.md
Name: pudding_loader

Overview:
- Host-side master for the PUDDING DAC serial load interface, on the same clock as the DAC core.
- Takes 128-bit DAC words over a valid/ready command port and drives the core's datum/shift/transfer/dir/enable pins: MSB-first shift, then transfer into state.
- Supports readback: transfer state to the daisychain, shift it out, sample the chain MSB output. Write-verify combines both and flags a mismatch.

Parameters:
- NBITS, 128, daisychain/state length in bits.
- DIV, 1, clk cycles per serial bit (>=1); shift_o pulses once per bit period.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  loader idle, command accepted when both high
- cmd_op  input  2  0 WRITE, 1 READ, 2 WRITE_VERIFY, 3 SET_EN
- cmd_data  input  NBITS  word to load; bit 0 = enable value for SET_EN
- rsp_valid  output  1  response available
- rsp_ready  input  1  response consumed
- rsp_data  output  NBITS  readback word (READ/WRITE_VERIFY), else 0
- rsp_mismatch  output  1  WRITE_VERIFY readback differs from written word
- datum_o  output  1  to core datum (ui_in[0])
- shift_o  output  1  to core shift (ui_in[1])
- transfer_o  output  1  to core transfer (ui_in[2])
- dir_o  output  1  to core dir (ui_in[3])
- en_o  output  1  to core enable (ui_in[4])
- sdo_i  input  1  core daisychain MSB (uo_out[7])

Behaviour:
- Interface fixed: one clock `clk`; reset `rst_n` synchronous, active-low.
- All pin outputs are registered.
- Reset: FSM IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_mismatch=0, all pin outputs 0 including en_o.
- Reset mid-operation: the same values apply on the next edge. The partial shift is abandoned and no response is issued.
- cmd_ready=1 only in IDLE. A command is accepted on the cycle cmd_valid&&cmd_ready; cmd_data is latched at that edge.
- States: IDLE, SHIFT_W, XFER_W, XFER_R, SHIFT_R, RESP.
- WRITE: IDLE → SHIFT_W → XFER_W → RESP.
  - SHIFT_W has NBITS bit periods of DIV cycles each.
  - In bit period i (i=0..NBITS-1), datum_o = word[NBITS-1-i] for the whole period. shift_o=1 only in the last cycle of the period.
  - XFER_W is one cycle with transfer_o=1, dir_o=1, shift_o=0.
  - The first rsp_valid comes NBITS*DIV+2 cycles after acceptance.
- READ: IDLE → XFER_R → SHIFT_R → RESP.
  - XFER_R is one cycle with transfer_o=1, dir_o=0.
  - SHIFT_R has NBITS bit periods with datum_o=0 and shift_o on the last cycle of each period.
  - In bit period i, sdo_i is sampled in the shift_o cycle into rsp_data[NBITS-1-i].
- WRITE_VERIFY: WRITE sequence (without RESP), then READ sequence.
  - rsp_mismatch = (readback != latched word).
  - rsp_data = readback.
- SET_EN: en_o <= cmd_data[0] on the acceptance edge. RESP is entered next cycle with rsp_data=0.
- Invariants:
  - transfer_o and shift_o are never both 1.
  - dir_o=0 except in the XFER_W cycle.
  - en_o holds its value across all other ops.
- RESP: rsp_valid=1 until rsp_ready is sampled high, then return to IDLE.
  - cmd_ready stays 0 throughout RESP.
  - rsp_data and rsp_mismatch are stable while rsp_valid=1.
  - rsp_mismatch is 0 for ops other than WRITE_VERIFY.
- Counters:
  - bit counter is $clog2(NBITS+1) wide; no wrap-around past NBITS.
  - div counter is $clog2(DIV) wide, or absent when DIV=1.
- Illegal cmd_data bits for SET_EN (bits NBITS-1:1) are ignored.

Decomposition:
- Shared package pudding_pkg:
  - op enum pudding_op_e (OP_WRITE, OP_READ, OP_WRITE_VERIFY, OP_SET_EN)
  - FSM state enum
  - localparam PUDDING_NBITS=128
- One sub-module, pudding_bit_timer, owns the DIV and bit counters. It outputs bit_strobe (last cycle of each bit period) and last_bit.

Test Plan:
- Reset, then WRITE of 128'h8000...0001 with DIV=1:
  - datum_o is 1 on the first and last shift cycles, 0 elsewhere.
  - transfer_o and dir_o are 1 at cycle 129 after acceptance.
  - rsp_valid appears at cycle 130.
  - A core model's state equals the word.
- READ against a core model holding 128'hDEADBEEF_0123...: rsp_data equals the model state and the model state is unchanged.
- WRITE_VERIFY of 128'hA5A5... with the model's bit 64 stuck-at-0: rsp_mismatch=1 and rsp_data[64]=0; with a clean model, rsp_mismatch=0.
- DIV=4 WRITE: the shift_o pulse period is 4 cycles, datum_o is stable across each period, and the total latency to rsp_valid is 514.
- SET_EN with data 1, then WRITE:
  - en_o=1 throughout the WRITE.
  - cmd_valid during the WRITE is ignored (cmd_ready=0).
  - Holding rsp_ready=0 keeps rsp_valid asserted.
- rst_n low at bit 40 of a WRITE: all pins are 0 on the next edge, no rsp_valid, cmd_ready=1. A following WRITE completes correctly.
